// File: rtl/data_bus_and_arbiter.sv
// Round-robin arbiter that time-shares one registered AND-reduction unit
// (out = a & b & c) among NUM_REQ requesters, returning result plus winner ID.
module data_bus_and_arbiter #(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned NUM_REQ = 3,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  input  logic [NUM_REQ*WIDTH-1:0] req_c,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [WIDTH-1:0]         rsp_data,
  output logic [ID_W-1:0]          rsp_id,
  output logic                     busy,
  output logic [15:0]              done_count
);

  typedef enum logic [1:0] {StIdle, StCompute, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   cur_id_q, cur_id_d;
  logic [WIDTH-1:0]  op_a_q, op_a_d;
  logic [WIDTH-1:0]  op_b_q, op_b_d;
  logic [WIDTH-1:0]  op_c_q, op_c_d;
  logic [WIDTH-1:0]  rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [15:0]       done_count_q, done_count_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W:0]     cand_sum;
  logic [ID_W-1:0]   ptr_after_grant;
  logic [WIDTH-1:0]  bus_out;

  // Round-robin search: first valid requester at or after rr_ptr, modulo NUM_REQ.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand_sum    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
        cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!grant_found && req_valid[cand_sum[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_sum[ID_W-1:0];
      end
    end
  end

  assign ptr_after_grant = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

  // Shared reduction unit, fed only from the operand registers so late
  // operand changes on the request side cannot reach the result.
  assign bus_out = op_a_q & op_b_q & op_c_q;

  // Next-state and handshake decode.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cur_id_d     = cur_id_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    op_c_d       = op_c_q;
    rsp_data_d   = rsp_data_q;
    rsp_id_d     = rsp_id_q;
    done_count_d = done_count_q;
    req_ready    = '0;
    unique case (state_q)
      StIdle: begin
        if (grant_found) begin
          req_ready[grant_idx] = 1'b1;
          op_a_d   = req_a[32'(grant_idx)*WIDTH +: WIDTH];
          op_b_d   = req_b[32'(grant_idx)*WIDTH +: WIDTH];
          op_c_d   = req_c[32'(grant_idx)*WIDTH +: WIDTH];
          cur_id_d = grant_idx;
          rr_ptr_d = ptr_after_grant;
          state_d  = StCompute;
        end
      end
      StCompute: begin
        rsp_data_d = bus_out;
        rsp_id_d   = cur_id_q;
        state_d    = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          done_count_d = done_count_q + 16'd1;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      rr_ptr_q     <= '0;
      cur_id_q     <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_c_q       <= '0;
      rsp_data_q   <= '0;
      rsp_id_q     <= '0;
      done_count_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cur_id_q     <= cur_id_d;
      op_a_q       <= op_a_d;
      op_b_q       <= op_b_d;
      op_c_q       <= op_c_d;
      rsp_data_q   <= rsp_data_d;
      rsp_id_q     <= rsp_id_d;
      done_count_q <= done_count_d;
    end
  end

  assign rsp_valid  = (state_q == StResp);
  assign busy       = (state_q != StIdle);
  assign rsp_data   = rsp_data_q;
  assign rsp_id     = rsp_id_q;
  assign done_count = done_count_q;

endmodule

// File: tb/tb_data_bus_and_arbiter.sv
// Directed, table-driven bench for data_bus_and_arbiter (8-bit and 16-bit instances).
module tb_data_bus_and_arbiter;

  localparam int unsigned N  = 3;
  localparam int unsigned W  = 8;
  localparam int unsigned WW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b, req_c;
  logic           rsp_valid, rsp_ready, busy;
  logic [W-1:0]   rsp_data;
  logic [1:0]     rsp_id;
  logic [15:0]    done_count;

  logic [N-1:0]    w_req_valid, w_req_ready;
  logic [N*WW-1:0] w_req_a, w_req_b, w_req_c;
  logic            w_rsp_valid, w_rsp_ready, w_busy;
  logic [WW-1:0]   w_rsp_data;
  logic [1:0]      w_rsp_id;
  logic [15:0]     w_done_count;

  data_bus_and_arbiter #(.WIDTH(W), .NUM_REQ(N)) u_dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_c      (req_c),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .done_count (done_count)
  );

  data_bus_and_arbiter #(.WIDTH(WW), .NUM_REQ(N)) u_wide (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (w_req_valid),
    .req_ready  (w_req_ready),
    .req_a      (w_req_a),
    .req_b      (w_req_b),
    .req_c      (w_req_c),
    .rsp_valid  (w_rsp_valid),
    .rsp_ready  (w_rsp_ready),
    .rsp_data   (w_rsp_data),
    .rsp_id     (w_rsp_id),
    .busy       (w_busy),
    .done_count (w_done_count)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [23:0] a;
    logic [23:0] b;
    logic [23:0] c;
    logic [2:0]  grant;
    logic [7:0]  data;
    logic [1:0]  id;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  initial begin
    // Single request, pointer advance, then fairness with all three valid.
    vecs[0] = '{3'b010, 24'h00F000, 24'h003C00, 24'h00FF00, 3'b010, 8'h30, 2'd1};
    vecs[1] = '{3'b100, 24'hAA0000, 24'hF00000, 24'h3F0000, 3'b100, 8'h20, 2'd2};
    vecs[2] = '{3'b101, 24'hFF005A, 24'hFF00FF, 24'hFF000F, 3'b001, 8'h0A, 2'd0};
    vecs[3] = '{3'b100, 24'h810000, 24'hC30000, 24'hFF0000, 3'b100, 8'h81, 2'd2};
    vecs[4] = '{3'b111, 24'h442211, 24'h4C2A19, 24'hF00FFF, 3'b001, 8'h11, 2'd0};
    vecs[5] = '{3'b111, 24'h442211, 24'h4C2A19, 24'hF00FFF, 3'b010, 8'h02, 2'd1};
    vecs[6] = '{3'b111, 24'h442211, 24'h4C2A19, 24'hF00FFF, 3'b100, 8'h40, 2'd2};
    vecs[7] = '{3'b111, 24'h442211, 24'h4C2A19, 24'hF00FFF, 3'b001, 8'h11, 2'd0};
    vecs[8] = '{3'b111, 24'h442211, 24'h4C2A19, 24'hF00FFF, 3'b010, 8'h02, 2'd1};
    vecs[9] = '{3'b111, 24'h442211, 24'h4C2A19, 24'hF00FFF, 3'b100, 8'h40, 2'd2};

    rst = 1'b1;
    req_valid = '0; req_a = '0; req_b = '0; req_c = '0; rsp_ready = 1'b1;
    w_req_valid = '0; w_req_a = '0; w_req_b = '0; w_req_c = '0; w_rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset req_ready", 32'(req_ready), 32'd0);
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_data", 32'(rsp_data), 32'd0);
    chk("reset rsp_id", 32'(rsp_id), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done_count", 32'(done_count), 32'd0);

    // One full transaction per vector; accepts land every 3 cycles.
    for (int i = 0; i < 10; i++) begin
      req_valid = vecs[i].valid;
      req_a = vecs[i].a; req_b = vecs[i].b; req_c = vecs[i].c;
      #1;
      chk($sformatf("v%0d req_ready", i), 32'(req_ready), 32'(vecs[i].grant));
      chk($sformatf("v%0d busy idle", i), 32'(busy), 32'd0);
      @(posedge clk); #1;
      req_valid = '0;
      chk($sformatf("v%0d busy T+1", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d rsp_valid T+1", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d req_ready T+1", i), 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      chk($sformatf("v%0d rsp_valid T+2", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d rsp_data", i), 32'(rsp_data), 32'(vecs[i].data));
      chk($sformatf("v%0d rsp_id", i), 32'(rsp_id), 32'(vecs[i].id));
      @(posedge clk); #1;
      chk($sformatf("v%0d done_count", i), 32'(done_count), 32'(i + 1));
      chk($sformatf("v%0d busy after", i), 32'(busy), 32'd0);
    end

    // Backpressure: five stalled cycles in RESP with other requesters waiting.
    rsp_ready = 1'b0;
    req_valid = 3'b001;
    req_a = 24'h00003C; req_b = 24'h0000F3; req_c = 24'h0000FF;
    #1 chk("bp req_ready", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    req_valid = 3'b110;
    @(posedge clk); #1;
    for (int s = 0; s < 5; s++) begin
      chk($sformatf("bp%0d rsp_valid", s), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d rsp_data", s), 32'(rsp_data), 32'h30);
      chk($sformatf("bp%0d rsp_id", s), 32'(rsp_id), 32'd0);
      chk($sformatf("bp%0d req_ready", s), 32'(req_ready), 32'd0);
      chk($sformatf("bp%0d done_count", s), 32'(done_count), 32'd10);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    chk("bp rsp_valid release", 32'(rsp_valid), 32'd1);
    @(posedge clk); #1;
    chk("bp done_count", 32'(done_count), 32'd11);
    chk("bp busy", 32'(busy), 32'd0);

    // Reset during COMPUTE drops the transaction.
    req_valid = 3'b010;
    req_a = 24'h00FF00; req_b = 24'h00FF00; req_c = 24'h00FF00;
    #1 chk("rst req_ready", 32'(req_ready), 32'b010);
    @(posedge clk); #1;
    chk("rst busy compute", 32'(busy), 32'd1);
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst rsp_data", 32'(rsp_data), 32'd0);
    chk("rst rsp_id", 32'(rsp_id), 32'd0);
    chk("rst done_count", 32'(done_count), 32'd0);
    chk("rst req_ready", 32'(req_ready), 32'd0);
    for (int s = 0; s < 4; s++) begin
      @(posedge clk); #1;
      chk($sformatf("rst quiet%0d rsp_valid", s), 32'(rsp_valid), 32'd0);
    end
    req_valid = 3'b111;
    req_a = 24'h442211; req_b = 24'h4C2A19; req_c = 24'hF00FFF;
    #1 chk("post-rst grant", 32'(req_ready), 32'b001);
    @(posedge clk); #1;
    req_valid = '0;
    @(posedge clk); #1;
    chk("post-rst rsp_data", 32'(rsp_data), 32'h11);
    chk("post-rst rsp_id", 32'(rsp_id), 32'd0);
    @(posedge clk); #1;
    chk("post-rst done_count", 32'(done_count), 32'd1);

    // 16-bit instance.
    w_req_valid = 3'b001;
    w_req_a = 48'h0000_0000_FFFF;
    w_req_b = 48'h0000_0000_0F0F;
    w_req_c = 48'h0000_0000_00FF;
    #1 chk("wide req_ready", 32'(w_req_ready), 32'b001);
    @(posedge clk); #1;
    w_req_valid = '0;
    @(posedge clk); #1;
    chk("wide rsp_valid", 32'(w_rsp_valid), 32'd1);
    chk("wide rsp_data", 32'(w_rsp_data), 32'h000F);
    chk("wide rsp_id", 32'(w_rsp_id), 32'd0);
    @(posedge clk); #1;
    chk("wide done_count", 32'(w_done_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/data_bus_and_arbiter.md
# data_bus_and_arbiter

Round-robin arbiter and sequencer that shares one `data_bus_if`-driven AND-reduction unit (`out = a & b & c`) among `NUM_REQ` requesters. Each requester offers an operand triple through a valid/ready handshake. The block grants one requester at a time and drives the shared bus from registered operands. It returns the registered result with the winner's ID on a single valid/ready response channel. It sits between multiple client blocks and the single shared reduction datapath.

## Interface
- `WIDTH`, 8: operand and result width; the shared bus is instantiated with this width.
- `NUM_REQ`, 3: number of requesters, legal range 2..16.
- `ID_W`, `$clog2(NUM_REQ)`: response ID width (derived, not overridden).
- Clocking and reset: one clock; reset is synchronous and active-high.

- `clk` input 1: sole clock, rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input NUM_REQ: per-requester request valid.
- `req_ready` output NUM_REQ: per-requester accept; at most one bit high.
- `req_a`, `req_b`, `req_c` input NUM_REQ*WIDTH: flattened operands; requester i occupies bits [i*WIDTH +: WIDTH].
- `rsp_valid` output 1: response valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_data` output WIDTH: registered AND result.
- `rsp_id` output ID_W: index of the requester that owns `rsp_data`.
- `busy` output 1: high in every state except IDLE.
- `done_count` output 16: count of completed responses; wraps at 16 bits.

## Operation
- FSM states: IDLE, COMPUTE, RESP.
- **IDLE**
  - If any `req_valid` is high, select the winner with round-robin priority: search from `rr_ptr` upward, modulo NUM_REQ.
  - Assert `req_ready[winner]` combinationally in this cycle.
  - At the clock edge, capture the winner's a/b/c into the bus operand registers and the winner index into `cur_id`.
  - Set `rr_ptr <= (winner+1) mod NUM_REQ`. Transition to COMPUTE.
  - With no `req_valid`, stay in IDLE; `rr_ptr` is unchanged.
- **COMPUTE**
  - The shared unit output is registered into `rsp_data`, and `cur_id` is registered into `rsp_id`.
  - Transition to RESP.
- **RESP**
  - `rsp_valid` = 1.
  - On `rsp_valid && rsp_ready`: go to IDLE and increment `done_count`.
  - Otherwise hold, with `rsp_data` and `rsp_id` stable.
- `req_ready` is 0 in COMPUTE and RESP. Requesters must hold valid and operands stable until accepted and must not make `req_valid` depend on `req_ready`.
- A requester that drops `req_valid` before grant loses its turn with no side effect.
- Values after reset:
  - State = IDLE, `rr_ptr` = 0.
  - `req_ready` = 0, `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0.
  - Operand registers = 0, `busy` = 0, `done_count` = 0.
- Reset asserted in COMPUTE or RESP discards the in-flight transaction; no response is ever produced for it.
- `done_count` wraps from 0xFFFF to 0x0000.

## Timing
- The accept handshake occurs in cycle T.
- The earliest `rsp_valid` is at T+2. The response completes at T+2 when `rsp_ready` is held at 1.
- The earliest next accept is T+3, giving a maximum throughput of one transaction per 3 cycles.
- Stall cycles on `rsp_ready` add 1:1 to latency.
- `busy` rises in cycle T+1 and falls in the cycle after the response handshake.
- The result depends only on the operands latched at accept. Operand changes on any requester after accept have no effect.

## Test plan
1. **Single request, no stall.** WIDTH=8, requester 1 presents a=0xF0, b=0x3C, c=0xFF, with `rsp_ready`=1.
   - Required: `req_ready`=3'b010 in cycle T.
   - Required at T+2: `rsp_valid`=1, `rsp_data`=0x30, `rsp_id`=1.
   - Required: `done_count`=1.
2. **Fairness.** All three `req_valid` held high, `rsp_ready`=1.
   - Required: grants in order 0,1,2,0,1,2, one accept every 3 cycles.
   - Required: `rsp_id` sequence matches the grant order.
3. **Pointer advance.** Only requester 2 is valid and is served; then requesters 0 and 2 are valid together.
   - Required: requester 0 is granted next.
4. **Backpressure.** `rsp_ready`=0 for 5 cycles while in RESP.
   - Required: `rsp_valid` stays 1 and `rsp_data`/`rsp_id` are stable.
   - Required: no `req_ready` bit is asserted and `done_count` does not increment until the handshake.
5. **Reset mid-operation.** Assert `rst` for 1 cycle during COMPUTE.
   - Required: `rsp_valid` never rises for that transaction and all outputs return to reset values.
   - Required: with all requesters valid after reset, requester 0 is granted first.
6. **Wide instance.** WIDTH=16, a=0xFFFF, b=0x0F0F, c=0x00FF.
   - Required: `rsp_data`=0x000F.
